// File: rtl/payload_engine_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : payload_engine_pkg
// Purpose  : Shared definitions for the payload character decoder: default
//            class count, byte-to-class table, FSM state encoding and the
//            drain bubble length.
// Revision : 1.0 - initial release
// ============================================================================
package payload_engine_pkg;

   // Number of character-class match lines presented to the engines.
   localparam int c_NCLASS_DEF = 37;

   // Cycles the input is held off after a packet ends.
   localparam int c_DRAIN_LEN = 3;

   // Class bit assignments.
   //   0..25 : letters a..z (case-insensitive)
   //   26    : decimal digit
   //   27    : whitespace \s (HT, LF, VT, FF, CR, space)
   //   28..34: ':' '/' '-' '.' '=' '&' '?'
   //   35    : word character \w [A-Za-z0-9_]
   //   36    : hex digit [0-9A-Fa-f]
   localparam int c_CLS_ALPHA0 = 0;
   localparam int c_CLS_DIGIT  = 26;
   localparam int c_CLS_SPACE  = 27;
   localparam int c_CLS_COLON  = 28;
   localparam int c_CLS_SLASH  = 29;
   localparam int c_CLS_DASH   = 30;
   localparam int c_CLS_DOT    = 31;
   localparam int c_CLS_EQ     = 32;
   localparam int c_CLS_AMP    = 33;
   localparam int c_CLS_QMARK  = 34;
   localparam int c_CLS_WORD   = 35;
   localparam int c_CLS_HEX    = 36;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PKT   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Byte-to-class lookup. Letters are folded to lower case before matching.
   function automatic logic [c_NCLASS_DEF-1:0] byte_class(input logic [7:0] b);
      logic [c_NCLASS_DEF-1:0] cls;
      logic                    is_alpha;
      logic                    is_digit;
      logic [7:0]              lower;
      cls      = '0;
      is_alpha = ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
      is_digit = (b >= 8'h30) && (b <= 8'h39);
      lower    = b | 8'h20;
      for (int i = 0; i < 26; i++) begin
         if (is_alpha && (lower == 8'(8'h61 + i))) begin
            cls[c_CLS_ALPHA0 + i] = 1'b1;
         end
      end
      cls[c_CLS_DIGIT] = is_digit;
      cls[c_CLS_SPACE] = (b == 8'h09) || (b == 8'h0A) || (b == 8'h0B) ||
                         (b == 8'h0C) || (b == 8'h0D) || (b == 8'h20);
      cls[c_CLS_COLON] = (b == 8'h3A);
      cls[c_CLS_SLASH] = (b == 8'h2F);
      cls[c_CLS_DASH]  = (b == 8'h2D);
      cls[c_CLS_DOT]   = (b == 8'h2E);
      cls[c_CLS_EQ]    = (b == 8'h3D);
      cls[c_CLS_AMP]   = (b == 8'h26);
      cls[c_CLS_QMARK] = (b == 8'h3F);
      cls[c_CLS_WORD]  = is_alpha || is_digit || (b == 8'h5F);
      cls[c_CLS_HEX]   = is_digit || (is_alpha && (lower >= 8'h61) && (lower <= 8'h66));
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/payload_char_class.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : payload_char_class
// Purpose  : Combinational byte-to-class lookup using the shared table.
//            Class lines beyond the table width read as zero.
// Ports    : i_byte - payload byte
//            o_cls  - NCLASS-bit class match vector
// Revision : 1.0 - initial release
// ============================================================================
module payload_char_class
   import payload_engine_pkg::*;
#(
   parameter int NCLASS = c_NCLASS_DEF
)(
   input  logic [7:0]        i_byte,
   output logic [NCLASS-1:0] o_cls
);

   logic [c_NCLASS_DEF-1:0] w_full;

   assign w_full = byte_class(i_byte);

   for (genvar gi = 0; gi < NCLASS; gi++) begin : g_bit
      if (gi < c_NCLASS_DEF) begin : g_tab
         assign o_cls[gi] = w_full[gi];
      end else begin : g_pad
         assign o_cls[gi] = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/payload_char_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : payload_char_decoder
// Purpose  : Accepts a byte stream framed by sop/eop, classifies each payload
//            byte and presents per-class match lines to downstream engines
//            with clear (sod_o), enable (en_o) and done (pkt_done_o) strobes.
//            A 3-cycle drain bubble after each packet lets the engines settle.
// Ports    : clk, rst           - clock, async active-high reset
//            s_data/s_valid/s_sop/s_eop/s_ready - input byte stream
//            cls_o, en_o        - class vector and engine enable (beat k+2)
//            sod_o              - engine clear (sop beat k+1)
//            anchor_o           - first byte of payload marker
//            pkt_done_o         - engine result valid (eop beat k+4)
//            drop_cnt_o         - saturating count of discarded beats
// Config   : PAYLOAD_ANCHOR_EN  - when defined, anchor_o marks the sop beat;
//                                 otherwise anchor_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module payload_char_decoder
   import payload_engine_pkg::*;
#(
   parameter int NCLASS = c_NCLASS_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   input  logic              s_sop,
   input  logic              s_eop,
   output logic              s_ready,
   output logic [NCLASS-1:0] cls_o,
   output logic              en_o,
   output logic              sod_o,
   output logic              anchor_o,
   output logic              pkt_done_o,
   output logic [15:0]       drop_cnt_o
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_drain_cnt;
   logic [1:0]        w_drain_nxt;
   logic              r_alive;

   logic              w_ready;
   logic              w_accept;
   logic              w_start;
   logic              w_payload;
   logic              w_drop_inc;

   logic              r_sod;
   logic              r1_vld;
   logic [7:0]        r1_data;
   logic              r1_eop;
   logic              r_en;
   logic [NCLASS-1:0] r_cls;
   logic              r2_eop;
   logic              r3_eop;
   logic              r_done;
   logic [15:0]       r_drop;
   logic [NCLASS-1:0] w_cls;

   // Holds s_ready low while in reset and raises it on the first edge after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alive <= 1'b0;
      end else begin
         r_alive <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_drain_cnt <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && s_sop) begin
               if (s_eop) begin
                  w_state_nxt = ST_DRAIN;
                  w_drain_nxt = 2'(c_DRAIN_LEN - 1);
               end else begin
                  w_state_nxt = ST_PKT;
               end
            end
         end
         ST_PKT: begin
            if (w_accept && s_eop) begin
               w_state_nxt = ST_DRAIN;
               w_drain_nxt = 2'(c_DRAIN_LEN - 1);
            end
         end
         ST_DRAIN: begin
            if (r_drain_cnt == 2'd0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_drain_nxt = r_drain_cnt - 2'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- outputs
   always_comb begin
      w_ready    = r_alive && (r_state != ST_DRAIN);
      w_accept   = s_valid && w_ready;
      w_start    = w_accept && (r_state == ST_IDLE) && s_sop;
      w_payload  = w_start || (w_accept && (r_state == ST_PKT));
      // Stray beats in IDLE are dropped; a repeated sop inside a packet is
      // kept as payload but still counted as a framing anomaly.
      w_drop_inc = w_accept && (((r_state == ST_IDLE) && !s_sop) ||
                                ((r_state == ST_PKT) && s_sop));
   end

   assign s_ready = w_ready;

   // --------------------------------------------------------- lookup stage
   payload_char_class #(
      .NCLASS (NCLASS)
   ) u_char_class (
      .i_byte (r1_data),
      .o_cls  (w_cls)
   );

   // Stage 1 captures the accepted beat, stage 2 presents the class vector.
   // The eop flag rides two extra stages so pkt_done_o lands two cycles
   // after the last enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sod   <= 1'b0;
         r1_vld  <= 1'b0;
         r1_data <= 8'd0;
         r1_eop  <= 1'b0;
         r_en    <= 1'b0;
         r_cls   <= '0;
         r2_eop  <= 1'b0;
         r3_eop  <= 1'b0;
         r_done  <= 1'b0;
         r_drop  <= 16'd0;
      end else begin
         r_sod   <= w_start;
         r1_vld  <= w_payload;
         r1_data <= s_data;
         r1_eop  <= w_payload && s_eop;
         r_en    <= r1_vld;
         r_cls   <= r1_vld ? w_cls : '0;
         r2_eop  <= r1_eop;
         r3_eop  <= r2_eop;
         r_done  <= r3_eop;
         if (w_drop_inc && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
         end
      end
   end

   assign sod_o      = r_sod;
   assign en_o       = r_en;
   assign cls_o      = r_cls;
   assign pkt_done_o = r_done;
   assign drop_cnt_o = r_drop;

`ifdef PAYLOAD_ANCHOR_EN
   logic r1_anchor;
   logic r_anchor;

   // Follows the sop beat through the same two stages as en_o.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_anchor <= 1'b0;
         r_anchor  <= 1'b0;
      end else begin
         r1_anchor <= w_start;
         r_anchor  <= r1_anchor;
      end
   end

   assign anchor_o = r_anchor;
`else
   assign anchor_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/payload_char_decoder.md
PAYLOAD_CHAR_DECODER -- requirements
Module: payload_char_decoder

Interface
REQ-001 SHALL have parameter NCLASS, default 37, meaning the number of character-class match lines driven to the engines (in_0..in_36).
REQ-002 SHALL have ports: clk input 1, the single clock; rst input 1, asynchronous active-high reset.
REQ-003 SHALL have ports: s_data input 8, payload byte; s_valid input 1, beat present; s_sop input 1, first byte of payload; s_eop input 1, last byte of payload; s_ready output 1, beat accepted when s_valid and s_ready are both high.
REQ-004 SHALL have ports: cls_o output NCLASS, per-class match of the current byte; en_o output 1, engine clock-enable; sod_o output 1, engine clear pulse; anchor_o output 1, first byte of payload.
REQ-005 SHALL have ports: pkt_done_o output 1, engine outputs valid for sampling; drop_cnt_o output 16, count of discarded beats.

Function
REQ-006 SHALL implement the FSM IDLE -> PKT on an accepted sop beat, PKT -> DRAIN on an accepted eop beat, and DRAIN -> IDLE after 3 cycles; an accepted beat carrying both sop and eop SHALL go IDLE -> DRAIN.
REQ-007 SHALL drive s_ready high in IDLE and PKT, and low in DRAIN and during reset.
REQ-008 SHALL, for an accepted sop beat in cycle k, pulse sod_o high for exactly cycle k+1.
REQ-009 SHALL, for every accepted beat in a packet in cycle k, drive en_o high and cls_o = class(s_data) in cycle k+2.
REQ-010 SHALL drive cls_o to all-zero whenever en_o is low.
REQ-011 SHALL compute class(b) so that bit i is high iff byte b is a member of class i in the shared table, with letter classes case-insensitive.
REQ-012 SHALL, for an eop beat accepted in cycle k, pulse pkt_done_o high for exactly cycle k+4, which is 2 cycles after the last en_o.
REQ-013 SHALL guarantee that the next sod_o occurs no earlier than cycle k+5, which the DRAIN bubble enforces.
REQ-014 SHALL, in IDLE, accept and discard any beat without sop, incrementing drop_cnt_o by 1 and saturating at 0xFFFF.
REQ-015 SHALL, in PKT, treat a beat with sop as ordinary payload (no sod_o) and SHALL increment drop_cnt_o.
REQ-016 SHALL keep the pipeline free of bubbles except for the DRAIN state; idle cycles with s_valid low in PKT produce en_o low.

Reset
REQ-017 SHALL, while rst is high, immediately force: FSM to IDLE, s_ready 0, cls_o 0, en_o 0, sod_o 0, anchor_o 0, pkt_done_o 0, drop_cnt_o 0, and all pipeline registers 0.
REQ-018 SHALL, on rst asserted mid-packet, discard any in-flight beats; after release, the first accepted beat SHALL require sop.
REQ-019 SHALL raise s_ready on the first clk edge after rst deasserts.

Configuration
REQ-020 SHALL, with macro PAYLOAD_ANCHOR_EN defined, drive anchor_o high together with the en_o of the sop beat only.
REQ-021 SHALL, without PAYLOAD_ANCHOR_EN, tie anchor_o to 0 and instantiate no anchor logic.

Structure
REQ-022 SHALL place NCLASS default, the byte-to-class table, the FSM state enum and the DRAIN length constant (3) in shared package payload_engine_pkg.
REQ-023 SHALL contain one combinational sub-module payload_char_class (byte in, NCLASS-bit vector out) performing the table lookup.

Verification
REQ-024 Single packet "User-Agent:" sent sop..eop with s_valid continuous from cycle 0 -> sod_o at cycle 1; en_o high in cycles 2..12; pkt_done_o at cycle 14; s_ready low in cycles 11..13.
REQ-025 Bytes 0x55 'U' and 0x75 'u' -> identical cls_o; byte 0x09 and byte 0x20 -> the \s class bit high; byte 0x3A -> only the ':' class bit(s) high.
REQ-026 Back-to-back packets with s_valid held high -> 3-cycle s_ready gap; second sod_o exactly 1 cycle after pkt_done_o; no en_o overlaps any sod_o.
REQ-027 Five beats without sop while IDLE -> no en_o, drop_cnt_o = 5; 0x10000 such beats -> drop_cnt_o = 0xFFFF.
REQ-028 rst pulsed during the 3rd byte of a packet -> all outputs 0 within the reset; next non-sop beat dropped; next sop beat -> sod_o resumes normally.
REQ-029 One-byte packet (sop and eop together) with PAYLOAD_ANCHOR_EN defined -> sod_o at k+1, en_o and anchor_o at k+2, pkt_done_o at k+4; without the macro, anchor_o stays 0.
